// File: rtl/input_conditioner.sv
`default_nettype none
// +------------------------------------------------------------------------------+
// | input_conditioner: N-channel pin synchroniser, debouncer and event generator. |
// | Optional build macro: INPUT_CONDITIONER_AUTOREPEAT_EN (press auto-repeat).    |
// | Revision: 1.0                                                                |
// +------------------------------------------------------------------------------+
module input_conditioner #(
  parameter int N_CH          = 5,
  parameter int DEBOUNCE_CYC  = 50000,
  parameter int ACTIVE_LOW    = 1,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] i_pin,
  input  logic [N_CH-1:0] i_ack,
  output logic [N_CH-1:0] o_level,
  output logic [N_CH-1:0] o_press,
  output logic [N_CH-1:0] o_release,
  output logic [N_CH-1:0] o_pending,
  output logic            o_any
);

  localparam int   CNT_W   = $clog2(DEBOUNCE_CYC + 1);
  localparam logic C_IDLE  = (ACTIVE_LOW != 0);
  localparam int   RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int   RPT_W   = $clog2(RPT_MAX + 1);

  if (N_CH < 1 || DEBOUNCE_CYC < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 || RPT_W < 1)
  begin : g_bad_param
    $error("input_conditioner: parameters out of range");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic             sync1_q, sync2_q, s;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             pending_q, pending_d;

    assign s = sync2_q ^ C_IDLE;

    // Any sample that agrees with the accepted level restarts the stability count.
    always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      if (s == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
        level_d = s;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
    logic [RPT_W-1:0] rpt_q, rpt_d;

    // rpt counts down to the next repeat; reaching zero while held fires a pulse.
    always_comb begin
      press_d = level_d & ~level_q;
      rpt_d   = rpt_q;
      if (level_d && !level_q) begin
        rpt_d = RPT_W'(REPEAT_DELAY - 1);
      end else if (!level_d) begin
        rpt_d = '0;
      end else if (rpt_q == '0) begin
        press_d = 1'b1;
        rpt_d   = RPT_W'(REPEAT_PERIOD - 1);
      end else begin
        rpt_d = rpt_q - 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rpt_q <= '0;
      else        rpt_q <= rpt_d;
    end
`else
    always_comb begin
      press_d = level_d & ~level_q;
    end
`endif

    always_comb begin
      release_d = level_q & ~level_d;
      pending_d = press_q | (pending_q & ~i_ack[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q   <= C_IDLE;
        sync2_q   <= C_IDLE;
        cnt_q     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        pending_q <= 1'b0;
      end else begin
        sync1_q   <= i_pin[i];
        sync2_q   <= sync1_q;
        cnt_q     <= cnt_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
        pending_q <= pending_d;
      end
    end

    assign o_level[i]   = level_q;
    assign o_press[i]   = press_q;
    assign o_release[i] = release_q;
    assign o_pending[i] = pending_q;
  end

  assign o_any = |o_level;

endmodule
`default_nettype wire

// File: tb/tb_input_conditioner.sv
`default_nettype none
// Self-checking bench for input_conditioner: random and directed stimulus vs. a rule-level model.
module tb_input_conditioner;
  localparam int N  = 5;
  localparam int DC = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] i_pin = '1;
  logic [N-1:0] i_ack = '0;
  logic [N-1:0] o_level, o_press, o_release, o_pending;
  logic         o_any;

  int checks = 0;
  int failures = 0;

  input_conditioner #(
    .N_CH(N), .DEBOUNCE_CYC(DC), .ACTIVE_LOW(1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_pin(i_pin), .i_ack(i_ack),
    .o_level(o_level), .o_press(o_press), .o_release(o_release),
    .o_pending(o_pending), .o_any(o_any)
  );

  always #5 clk = ~clk;

  // Model: a level flips once the last DC synchronised samples all disagree with it.
  bit [N-1:0] m_level, m_press, m_rel, m_pend;
  bit [N-1:0] m_hist[$];
  int         m_t0[N];
  int         m_cyc;

  function automatic void m_reset();
    m_level = '0; m_press = '0; m_rel = '0; m_pend = '0;
    m_hist.delete();
    for (int i = 0; i < DC + 2; i++) m_hist.push_back('0);
    for (int c = 0; c < N; c++) m_t0[c] = 0;
  endfunction

  function automatic void m_step(input bit [N-1:0] pin_ah, input bit [N-1:0] ack);
    bit [N-1:0] nl, np, nr, dropped;
    bit         all_diff;
    int         d;
    m_cyc++;
    m_hist.push_back(pin_ah);
    dropped = m_hist.pop_front();
    nl = m_level;
    np = '0;
    for (int c = 0; c < N; c++) begin
      all_diff = 1'b1;
      for (int k = 0; k < DC; k++) if (m_hist[k][c] == m_level[c]) all_diff = 1'b0;
      if (all_diff) nl[c] = ~m_level[c];
      if (nl[c] && !m_level[c]) begin
        np[c] = 1'b1;
        m_t0[c] = m_cyc;
      end
`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
      else if (nl[c] && m_level[c]) begin
        d = m_cyc - m_t0[c];
        if (d == RD || (d > RD && (d - RD) % RP == 0)) np[c] = 1'b1;
      end
`endif
    end
    nr = m_level & ~nl;
    m_pend  = m_press | (m_pend & ~ack);
    m_level = nl;
    m_press = np;
    m_rel   = nr;
  endfunction

  function automatic logic [4*N:0] dut_vec();
    return {o_level, o_press, o_release, o_pending, o_any};
  endfunction

  function automatic logic [4*N:0] mdl_vec();
    return {m_level, m_press, m_rel, m_pend, |m_level};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst_n) m_reset();
    else        m_step(~i_pin, i_ack);
    #1;
  endtask

  task automatic test_reset();
    m_reset();
    #2;
    checks++;
    if (dut_vec() !== '0) begin
      failures++;
      $display("FAIL reset_state: got %b expected 0", dut_vec());
    end
    tick(); tick();
    rst_n = 1'b1;
    for (int k = 0; k < 50; k++) begin
      tick();
      checks++;
      if (dut_vec() !== mdl_vec() || dut_vec() !== '0) begin
        failures++;
        $display("FAIL idle_after_reset cyc%0d: got %b expected 0", k, dut_vec());
      end
    end
  endtask

  task automatic test_glitch();
    i_pin[0] = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    i_pin[0] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      checks++;
      if (dut_vec() !== mdl_vec() || o_level[0] !== 1'b0 || o_pending[0] !== 1'b0) begin
        failures++;
        $display("FAIL glitch cyc%0d: got %b expected %b", k, dut_vec(), mdl_vec());
      end
    end
  endtask

  task automatic test_press_release();
    i_pin[0] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (dut_vec() !== mdl_vec() || o_level[0] !== (k >= 6) || o_press[0] !== (k == 6)
          || o_pending[0] !== (k >= 7) || o_any !== (k >= 6)) begin
        failures++;
        $display("FAIL press0 edge%0d: got %b expected %b", k, dut_vec(), mdl_vec());
      end
    end
    i_pin[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (dut_vec() !== mdl_vec() || o_level[0] !== (k < 6) || o_release[0] !== (k == 6)) begin
        failures++;
        $display("FAIL release0 edge%0d: got %b expected %b", k, dut_vec(), mdl_vec());
      end
    end
  endtask

  task automatic test_ack_collision();
    int n = 0;
    i_pin[2] = 1'b0;
    while (o_press[2] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (o_press[2] !== 1'b1) begin
      failures++;
      $display("FAIL ack_wait_press2: got o_press[2]=%b expected 1 within 20 edges", o_press[2]);
    end
    i_ack[2] = 1'b1;
    tick();
    i_ack[2] = 1'b0;
    checks++;
    if (o_pending[2] !== 1'b1 || dut_vec() !== mdl_vec()) begin
      failures++;
      $display("FAIL ack_collision: got pending2=%b expected 1", o_pending[2]);
    end
    tick(); tick();
    i_ack[2] = 1'b1;
    tick();
    i_ack[2] = 1'b0;
    checks++;
    if (o_pending[2] !== 1'b0 || dut_vec() !== mdl_vec()) begin
      failures++;
      $display("FAIL ack_clear: got pending2=%b expected 0", o_pending[2]);
    end
    i_pin[2] = 1'b1;
    for (int k = 0; k < 8; k++) tick();
  endtask

  task automatic test_simultaneous();
    int n = 0;
    i_pin[1] = 1'b0; i_pin[4] = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    i_pin[1] = 1'b1; i_pin[4] = 1'b1;
    while (o_release[1] !== 1'b1 && o_release[4] !== 1'b1 && n < 12) begin
      tick();
      n++;
    end
    checks++;
    if ({o_release[4], o_release[1]} !== 2'b11 || dut_vec() !== mdl_vec() || n != 6) begin
      failures++;
      $display("FAIL simultaneous_release: got rel4,rel1=%b after %0d edges expected 11 after 6",
               {o_release[4], o_release[1]}, n);
    end
    for (int k = 0; k < 4; k++) tick();
  endtask

  task automatic test_repeat();
    int got[$];
    int exp[$];
`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
    exp = '{6, 26, 34, 42, 50, 58};
`else
    exp = '{6};
`endif
    i_pin[3] = 1'b0;
    for (int k = 1; k <= 72; k++) begin
      tick();
      if (k == 60) i_pin[3] = 1'b1;
      if (o_press[3] === 1'b1) got.push_back(k);
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        failures++;
        $display("FAIL repeat_model edge%0d: got %b expected %b", k, dut_vec(), mdl_vec());
      end
    end
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL repeat_pulses: got %p expected %p", got, exp);
    end
    i_ack = '1; tick(); i_ack = '0; tick();
  endtask

  task automatic test_reset_mid();
    i_pin[0] = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    rst_n = 1'b0;
    m_reset();
    #1;
    checks++;
    if (dut_vec() !== '0) begin
      failures++;
      $display("FAIL async_reset: got %b expected 0", dut_vec());
    end
    tick(); tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (dut_vec() !== mdl_vec() || o_press[0] !== (k == 6)) begin
        failures++;
        $display("FAIL repress_after_reset edge%0d: got %b expected %b", k, dut_vec(), mdl_vec());
      end
    end
    i_pin[0] = 1'b1;
    for (int k = 0; k < 8; k++) tick();
  endtask

  task automatic test_random();
    int dur[N];
    for (int c = 0; c < N; c++) dur[c] = $urandom_range(1, 9);
    for (int k = 0; k < 800; k++) begin
      for (int c = 0; c < N; c++) begin
        dur[c]--;
        if (dur[c] <= 0) begin
          i_pin[c] = ~i_pin[c];
          dur[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 40) : $urandom_range(1, 9);
        end
        i_ack[c] = ($urandom_range(0, 3) == 0);
      end
      tick();
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        failures++;
        $display("FAIL random cyc%0d: got %b expected %b", k, dut_vec(), mdl_vec());
      end
    end
    i_pin = '1; i_ack = '0;
  endtask

  initial begin
    m_cyc = 0;
    test_reset();
    test_glitch();
    test_press_release();
    test_ack_collision();
    test_simultaneous();
    test_repeat();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
